// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - opcodes, state encoding and op-class decode for alu_op_sequencer
package alu_seq_pkg;

  localparam int OP_W = 5;

  typedef logic [OP_W-1:0] opcode_t;

  localparam opcode_t OP_ADD  = 5'b00011;
  localparam opcode_t OP_SUB  = 5'b00100;
  localparam opcode_t OP_SHR  = 5'b00101;
  localparam opcode_t OP_SHRA = 5'b00110;
  localparam opcode_t OP_SHL  = 5'b00111;
  localparam opcode_t OP_ROR  = 5'b01000;
  localparam opcode_t OP_ROL  = 5'b01001;
  localparam opcode_t OP_AND  = 5'b01010;
  localparam opcode_t OP_OR   = 5'b01011;
  localparam opcode_t OP_MUL  = 5'b01111;
  localparam opcode_t OP_DIV  = 5'b10000;
  localparam opcode_t OP_NEG  = 5'b10001;
  localparam opcode_t OP_NOT  = 5'b10010;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_T0,
    ST_T1,
    ST_T2,
    ST_T3,
    ST_T4,
    ST_T5,
    ST_T6,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    CLS_BIN,
    CLS_MULDIV,
    CLS_UNARY,
    CLS_ILLEGAL
  } op_class_e;

  function automatic op_class_e op_class(input opcode_t op);
    op_class_e cls;
    case (op)
      OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL,
      OP_ROR, OP_ROL, OP_AND, OP_OR:           cls = CLS_BIN;
      OP_MUL, OP_DIV:                          cls = CLS_MULDIV;
      OP_NEG, OP_NOT:                          cls = CLS_UNARY;
      default:                                 cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/reg_onehot_dec.sv
// rtl/reg_onehot_dec.sv - register index to one-hot select, all-zero for indices past NUM_REGS
module reg_onehot_dec #(
  parameter int NUM_REGS  = 16,
  parameter int REG_IDX_W = 4
) (
  input  logic [REG_IDX_W-1:0] idx,
  output logic [NUM_REGS-1:0]  onehot
);

  always_comb begin
    onehot = '0;
    if (32'(idx) < NUM_REGS) begin
      onehot[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - T-state control sequencer for one register-register ALU instruction
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 16,
  parameter int REG_IDX_W = 4,
  parameter int ALU_OP_W  = 5
) (
  input  logic                Clock,
  input  logic                Clear,
  input  logic                start,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   ir,
  output logic                busy,
  output logic                done,
  output logic                illegal,
  output logic                PCout,
  output logic                PCin,
  output logic                IncPC,
  output logic                MARin,
  output logic                Read,
  output logic                MDRin,
  output logic                MDRout,
  output logic                IRin,
  output logic                Yin,
  output logic                ZLowIn,
  output logic                ZHighIn,
  output logic                Zlowout,
  output logic                ZHighout,
  output logic                HIin,
  output logic                LOin,
  output logic [NUM_REGS-1:0] Rin,
  output logic [NUM_REGS-1:0] Rout,
  output logic [ALU_OP_W-1:0] alu_op
);

  localparam int RA_MSB = DATA_W - OP_W - 1;
  localparam int RB_MSB = RA_MSB - REG_IDX_W;
  localparam int RC_MSB = RB_MSB - REG_IDX_W;

  state_e                state, state_next;
  opcode_t               op;
  op_class_e             cls;
  logic [REG_IDX_W-1:0]  ra, rb, rc;
  logic [NUM_REGS-1:0]   sel_ra, sel_rb, sel_rc;

  // ir is stable from T3 onward since only T2 loads it
  assign op  = ir[DATA_W-1 -: OP_W];
  assign ra  = ir[RA_MSB -: REG_IDX_W];
  assign rb  = ir[RB_MSB -: REG_IDX_W];
  assign rc  = ir[RC_MSB -: REG_IDX_W];
  assign cls = op_class(op);

  generate
    if (RC_MSB >= REG_IDX_W) begin : g_ir_tail
      logic unused_ir_tail;
      assign unused_ir_tail = ^ir[RC_MSB-REG_IDX_W:0];
    end
  endgenerate

  reg_onehot_dec #(.NUM_REGS(NUM_REGS), .REG_IDX_W(REG_IDX_W)) u_dec_ra (
    .idx    (ra),
    .onehot (sel_ra)
  );

  reg_onehot_dec #(.NUM_REGS(NUM_REGS), .REG_IDX_W(REG_IDX_W)) u_dec_rb (
    .idx    (rb),
    .onehot (sel_rb)
  );

  reg_onehot_dec #(.NUM_REGS(NUM_REGS), .REG_IDX_W(REG_IDX_W)) u_dec_rc (
    .idx    (rc),
    .onehot (sel_rc)
  );

  always_ff @(posedge Clock) begin
    if (Clear) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_T0;
      ST_T0:   state_next = ST_T1;
      ST_T1:   if (mem_ready) state_next = ST_T2;
      ST_T2:   state_next = ST_T3;
      ST_T3:   state_next = (cls == CLS_ILLEGAL) ? ST_IDLE : ST_T4;
      ST_T4:   state_next = ST_T5;
      ST_T5:   state_next = (cls == CLS_MULDIV) ? ST_T6 : ST_DONE;
      ST_T6:   state_next = ST_DONE;
      ST_DONE: state_next = start ? ST_T0 : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != ST_IDLE);
    done     = 1'b0;
    illegal  = 1'b0;
    PCout    = 1'b0;
    PCin     = 1'b0;
    IncPC    = 1'b0;
    MARin    = 1'b0;
    Read     = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    ZLowIn   = 1'b0;
    ZHighIn  = 1'b0;
    Zlowout  = 1'b0;
    ZHighout = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    Rin      = '0;
    Rout     = '0;
    alu_op   = '0;
    case (state)
      ST_T0: begin
        PCout  = 1'b1;
        MARin  = 1'b1;
        IncPC  = 1'b1;
        ZLowIn = 1'b1;
      end
      ST_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = mem_ready;
      end
      ST_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      ST_T3: begin
        if (cls == CLS_BIN || cls == CLS_MULDIV) begin
          Rout = sel_rb;
          Yin  = 1'b1;
        end else if (cls == CLS_ILLEGAL) begin
          illegal = 1'b1;
        end
      end
      ST_T4: begin
        alu_op  = ALU_OP_W'(op);
        ZLowIn  = 1'b1;
        ZHighIn = (cls == CLS_MULDIV);
        Rout    = (cls == CLS_UNARY) ? sel_rb : sel_rc;
      end
      ST_T5: begin
        Zlowout = 1'b1;
        if (cls == CLS_MULDIV) begin
          LOin = 1'b1;
        end else begin
          Rin = sel_ra;
        end
      end
      ST_T6: begin
        ZHighout = 1'b1;
        HIin     = 1'b1;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - directed self-checking bench for alu_op_sequencer
module tb_alu_op_sequencer;

  logic        Clock;
  logic        Clear;
  logic        start;
  logic        mem_ready;
  logic [31:0] ir;
  logic        busy, done, illegal;
  logic        PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin, Yin;
  logic        ZLowIn, ZHighIn, Zlowout, ZHighout, HIin, LOin;
  logic [15:0] Rin, Rout;
  logic [4:0]  alu_op;
  logic [14:0] strb;

  int checks   = 0;
  int failures = 0;

  localparam logic [14:0] B_PCOUT  = 15'h4000;
  localparam logic [14:0] B_PCIN   = 15'h2000;
  localparam logic [14:0] B_INCPC  = 15'h1000;
  localparam logic [14:0] B_MARIN  = 15'h0800;
  localparam logic [14:0] B_READ   = 15'h0400;
  localparam logic [14:0] B_MDRIN  = 15'h0200;
  localparam logic [14:0] B_MDROUT = 15'h0100;
  localparam logic [14:0] B_IRIN   = 15'h0080;
  localparam logic [14:0] B_YIN    = 15'h0040;
  localparam logic [14:0] B_ZLIN   = 15'h0020;
  localparam logic [14:0] B_ZHIN   = 15'h0010;
  localparam logic [14:0] B_ZLOUT  = 15'h0008;
  localparam logic [14:0] B_ZHOUT  = 15'h0004;
  localparam logic [14:0] B_HIIN   = 15'h0002;
  localparam logic [14:0] B_LOIN   = 15'h0001;

  localparam logic [14:0] E_T0      = B_PCOUT | B_MARIN | B_INCPC | B_ZLIN;
  localparam logic [14:0] E_T1_WAIT = B_ZLOUT | B_PCIN | B_READ;
  localparam logic [14:0] E_T1_RDY  = B_ZLOUT | B_PCIN | B_READ | B_MDRIN;
  localparam logic [14:0] E_T2      = B_MDROUT | B_IRIN;

  assign strb = {PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin, Yin,
                 ZLowIn, ZHighIn, Zlowout, ZHighout, HIin, LOin};

  alu_op_sequencer dut (
    .Clock     (Clock),
    .Clear     (Clear),
    .start     (start),
    .mem_ready (mem_ready),
    .ir        (ir),
    .busy      (busy),
    .done      (done),
    .illegal   (illegal),
    .PCout     (PCout),
    .PCin      (PCin),
    .IncPC     (IncPC),
    .MARin     (MARin),
    .Read      (Read),
    .MDRin     (MDRin),
    .MDRout    (MDRout),
    .IRin      (IRin),
    .Yin       (Yin),
    .ZLowIn    (ZLowIn),
    .ZHighIn   (ZHighIn),
    .Zlowout   (Zlowout),
    .ZHighout  (ZHighout),
    .HIin      (HIin),
    .LOin      (LOin),
    .Rin       (Rin),
    .Rout      (Rout),
    .alu_op    (alu_op)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cs(input string tag, input logic [14:0] e_strb, input logic [15:0] e_rin,
                    input logic [15:0] e_rout, input logic [4:0] e_op, input logic e_busy,
                    input logic e_done, input logic e_ill);
    chk({tag, ".strb"}, 32'(strb), 32'(e_strb));
    chk({tag, ".rin"}, 32'(Rin), 32'(e_rin));
    chk({tag, ".rout"}, 32'(Rout), 32'(e_rout));
    chk({tag, ".alu_op"}, 32'(alu_op), 32'(e_op));
    chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
    chk({tag, ".done"}, 32'(done), 32'(e_done));
    chk({tag, ".illegal"}, 32'(illegal), 32'(e_ill));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_done;
    int second_done;

    Clear = 1'b1;
    start = 1'b0;
    mem_ready = 1'b1;
    ir = 32'h0;
    tick();
    tick();
    Clear = 1'b0;
    #1;
    cs("reset", 15'h0, 16'h0, 16'h0, 5'h0, 1'b0, 1'b0, 1'b0);

    // ROL r5 <- r2 rol r4
    ir = 32'h4A92_0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    cs("rol.t0", E_T0, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0, 1'b0);
    tick();
    cs("rol.t1", E_T1_RDY, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0, 1'b0);
    tick();
    cs("rol.t2", E_T2, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0, 1'b0);
    tick();
    cs("rol.t3", B_YIN, 16'h0, 16'h0004, 5'h0, 1'b1, 1'b0, 1'b0);
    tick();
    cs("rol.t4", B_ZLIN, 16'h0, 16'h0010, 5'b01001, 1'b1, 1'b0, 1'b0);
    tick();
    cs("rol.t5", B_ZLOUT, 16'h0020, 16'h0, 5'h0, 1'b1, 1'b0, 1'b0);
    tick();
    cs("rol.done7", 15'h0, 16'h0, 16'h0, 5'h0, 1'b1, 1'b1, 1'b0);
    tick();
    cs("rol.idle", 15'h0, 16'h0, 16'h0, 5'h0, 1'b0, 1'b0, 1'b0);

    // memory stall: three wait cycles in T1
    start = 1'b1;
    tick();
    start = 1'b0;
    mem_ready = 1'b0;
    cs("stall.t0", E_T0, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("stall.w1", 32'(strb), 32'(E_T1_WAIT));
    tick();
    chk("stall.w2", 32'(strb), 32'(E_T1_WAIT));
    tick();
    chk("stall.w3", 32'(strb), 32'(E_T1_WAIT));
    tick();
    mem_ready = 1'b1;
    #1;
    chk("stall.rdy", 32'(strb), 32'(E_T1_RDY));
    for (int c = 6; c <= 10; c++) begin
      tick();
      chk($sformatf("stall.done_c%0d", c), 32'(done), 32'(c == 10));
    end
    tick();

    // MUL r6 into HI/LO: Rb=3, Rc=6
    ir = 32'h781B_0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    cs("mul.t3", B_YIN, 16'h0, 16'h0008, 5'h0, 1'b1, 1'b0, 1'b0);
    tick();
    cs("mul.t4", B_ZLIN | B_ZHIN, 16'h0, 16'h0040, 5'b01111, 1'b1, 1'b0, 1'b0);
    tick();
    cs("mul.t5", B_ZLOUT | B_LOIN, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0, 1'b0);
    tick();
    cs("mul.t6", B_ZHOUT | B_HIIN, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0, 1'b0);
    tick();
    cs("mul.done8", 15'h0, 16'h0, 16'h0, 5'h0, 1'b1, 1'b1, 1'b0);
    tick();

    // NOT r1 <- ~r7
    ir = 32'h90B8_0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    cs("not.t3", 15'h0, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0, 1'b0);
    tick();
    cs("not.t4", B_ZLIN, 16'h0, 16'h0080, 5'b10010, 1'b1, 1'b0, 1'b0);
    tick();
    cs("not.t5", B_ZLOUT, 16'h0002, 16'h0, 5'h0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("not.done7", 32'(done), 32'h1);
    tick();

    // illegal opcode 11111
    ir = 32'hF800_0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    cs("ill.t3", 15'h0, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0, 1'b1);
    tick();
    cs("ill.idle", 15'h0, 16'h0, 16'h0, 5'h0, 1'b0, 1'b0, 1'b0);

    // Clear in T4 of ADD r1 <- r2 + r3
    ir = 32'h1891_8000;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    tick();
    cs("add.t4", B_ZLIN, 16'h0, 16'h0008, 5'b00011, 1'b1, 1'b0, 1'b0);
    Clear = 1'b1;
    tick();
    cs("clear.t4", 15'h0, 16'h0, 16'h0, 5'h0, 1'b0, 1'b0, 1'b0);
    Clear = 1'b0;
    tick();
    cs("clear.hold", 15'h0, 16'h0, 16'h0, 5'h0, 1'b0, 1'b0, 1'b0);

    // back-to-back issue with start held
    ir = 32'h4A92_0000;
    start = 1'b1;
    first_done = 0;
    second_done = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 8) begin
        chk("b2b.t0_strb", 32'(strb), 32'(E_T0));
        chk("b2b.t0_busy", 32'(busy), 32'h1);
      end
      if (done) begin
        if (first_done == 0) begin
          first_done = c;
        end else begin
          second_done = c;
          start = 1'b0;
          break;
        end
      end
    end
    chk("b2b.first_done", 32'(first_done), 32'd7);
    chk("b2b.second_done", 32'(second_done), 32'd14);
    tick();
    chk("b2b.idle_busy", 32'(busy), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
